counter: RTL and testbench

- Synchronous, width-parameterised binary up/down counter with count enable and direction select.
- General-purpose leaf block, synthesised to gates; bench runs with back-annotated timing, so RTL must be fully synthesisable with no initial blocks or delays.
- Single clock domain; asynchronous active-low reset.

---
 rtl/counter.sv | 56 +++++
 tb/tb_counter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// counter
//   Width-parameterised binary up/down counter with count enable and
//   direction select. COUNT wraps modulo 2^WIDTH in both directions; there is
//   no saturation and no carry/borrow output.
//
// Parameters
//   WIDTH    counter width in bits, 1..32 (default 4)
//
// Ports
//   CLOCK    in   1      system clock, all state changes on the rising edge
//   RESET    in   1      asynchronous active-low clear of the counter
//   ENABLE   in   1      1 = step on the next rising edge, 0 = hold
//   CONTROL  in   1      direction: 1 = up (+1), 0 = down (-1)
//   COUNT    out  WIDTH  current count, straight from the state register
// -----------------------------------------------------------------------------
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CONTROL,
  output logic [WIDTH-1:0] COUNT
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;

  // Both neighbours are formed in WIDTH bits so the carry/borrow out of the
  // top bit is simply dropped, which gives the modulo-2^WIDTH wrap.
  assign count_inc = count_q + WIDTH'(1);
  assign count_dec = count_q - WIDTH'(1);

  always_comb begin
    count_d = count_q;
    if (ENABLE) begin
      count_d = CONTROL ? count_inc : count_dec;
    end
  end

  // Clear is asynchronous and wins over any coincident clock edge.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;

endmodule

// File: tb/tb_counter.sv
`timescale 1ns/1ps
module tb_counter;

  logic       CLOCK;
  logic       RESET;
  logic       ENABLE;
  logic       CONTROL;
  logic [3:0] count4;
  logic [7:0] count8;

  counter #(.WIDTH(4)) dut4 (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .CONTROL(CONTROL),
    .COUNT  (count4)
  );

  counter #(.WIDTH(8)) dut8 (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .CONTROL(CONTROL),
    .COUNT  (count8)
  );

  // 200 ns period, first rising edge at 100 ns.
  initial begin
    CLOCK = 1'b0;
    forever #100 CLOCK = ~CLOCK;
  end

  typedef struct {
    time t;
    int  e4;
    int  e8;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the counter value as a plain integer, stepped by +/-1
  // and reduced modulo 2^WIDTH; any fall of RESET clears it. Each event
  // queues the value the DUT must show 1 ns later.
  int m4 = 0;
  int m8 = 0;
  initial begin
    forever begin
      @(posedge CLOCK or negedge RESET);
      if (RESET !== 1'b1) begin
        m4 = 0;
        m8 = 0;
      end else if (ENABLE === 1'b1) begin
        m4 = (m4 + (CONTROL ? 1 : -1) + 16) % 16;
        m8 = (m8 + (CONTROL ? 1 : -1) + 256) % 256;
      end
      sb_q.push_back('{t: $time + 1, e4: m4, e8: m8});
    end
  end

  // Monitor: pops each expectation and compares at its due time.
  initial begin
    exp_t e;
    forever begin
      while (sb_q.size() == 0) #1;
      e = sb_q.pop_front();
      if ($time < e.t) #(e.t - $time);
      total++;
      if (count4 !== 4'(e.e4)) begin
        bad++;
        $display("FAIL count4 t=%0t got=%0d want=%0d", $time, count4, e.e4);
      end
      total++;
      if (count8 !== 8'(e.e8)) begin
        bad++;
        $display("FAIL count8 t=%0t got=%0d want=%0d", $time, count8, e.e8);
      end
      $display("chk t=%0t en=%b up=%b rst=%b count4=%0d count8=%0d",
               $time, ENABLE, CONTROL, RESET, count4, count8);
    end
  end

  initial begin
    int rst_left;
    RESET   = 1'b1;
    ENABLE  = 1'b0;
    CONTROL = 1'b1;
    #20  RESET  = 1'b0;     // 20 ns: immediate clear
    #50  RESET  = 1'b1;     // 70 ns
    #500 ENABLE = 1'b1;     // 570 ns: up, 1 @700, 2 @900
    #500 CONTROL = 1'b0;    // 1070 ns: 1, 0, 15 (borrow wrap)
    #500 CONTROL = 1'b1;    // 1570 ns: 0 @1700 (carry wrap)
    #150 ENABLE = 1'b0;     // 1720 ns: hold
    #250 ENABLE = 1'b1;     // 1970 ns: 1 @2100, 2 @2300
    #450 RESET  = 1'b0;     // 2420 ns: async clear mid-count, enable high
    CONTROL = 1'b0;         // edges at 2500/2700 must be ignored
    #350 RESET  = 1'b1;     // 2770 ns: down from 0 -> 15/255 then 14/254
    #450 RESET  = 1'b0;     // 3220 ns
    CONTROL = 1'b1;
    #50  RESET  = 1'b1;     // 3270 ns: 17 up edges -> 1..15, 0, 1
    repeat (17) #200;
    // Random phase: inputs change 30 ns before each rising edge, with
    // occasional asynchronous reset pulses lasting one or two cycles.
    rst_left = 0;
    for (int i = 0; i < 1000; i++) begin
      ENABLE  = 1'($urandom_range(0, 1));
      CONTROL = 1'($urandom_range(0, 1));
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) RESET = 1'b1;
      end else if ($urandom_range(0, 49) == 0) begin
        RESET    = 1'b0;
        rst_left = $urandom_range(1, 2);
      end
      #200;
    end
    RESET = 1'b1;
    #250;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
